// File: rtl/exe_stage.sv
// Execute stage: combinational ALU and branch target, plus an iterative
// shift-add multiplier / restoring divider that stalls the front of the pipe.
module exe_stage #(
  parameter int DATA_WIDTH = 32,
  parameter bit MUL_DIV_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           PC_in,
  input  logic [DATA_WIDTH-1:0] Val1,
  input  logic [DATA_WIDTH-1:0] Val2,
  input  logic [DATA_WIDTH-1:0] Reg2,
  input  logic [4:0]            Dest,
  input  logic [3:0]            EXE_CMD,
  input  logic                  Br_taken_in,
  input  logic                  MEM_R_EN_in,
  input  logic                  MEM_W_EN_in,
  input  logic                  WB_EN_in,
  output logic [DATA_WIDTH-1:0] ALU_result,
  output logic [31:0]           Br_addr,
  output logic                  Br_taken,
  output logic [DATA_WIDTH-1:0] ST_value,
  output logic [4:0]            Dest_out,
  output logic                  MEM_R_EN,
  output logic                  MEM_W_EN,
  output logic                  WB_EN,
  output logic                  stall
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [3:0] CMD_ADD  = 4'b0000;
  localparam logic [3:0] CMD_SUB  = 4'b0010;
  localparam logic [3:0] CMD_AND  = 4'b0100;
  localparam logic [3:0] CMD_OR   = 4'b0101;
  localparam logic [3:0] CMD_NOR  = 4'b0110;
  localparam logic [3:0] CMD_XOR  = 4'b0111;
  localparam logic [3:0] CMD_SLL  = 4'b1000;
  localparam logic [3:0] CMD_SRA  = 4'b1001;
  localparam logic [3:0] CMD_SRL  = 4'b1010;
  localparam logic [3:0] CMD_MUL  = 4'b1100;
  localparam logic [3:0] CMD_DIVU = 4'b1101;
  localparam logic [3:0] CMD_REMU = 4'b1110;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        count_reg;
  logic [3:0]              cmd_reg;
  // a_reg: multiplier (shifted right) or dividend/quotient (shifted left)
  // b_reg: multiplicand (shifted left) or divisor; acc_reg: product or remainder
  logic [DATA_WIDTH-1:0]   a_reg, b_reg, acc_reg;
  logic [DATA_WIDTH:0]     div_shift;
  logic                    div_ge;
  logic                    is_multi;
  logic [DATA_WIDTH-1:0]   alu_result;
  logic [DATA_WIDTH-1:0]   engine_result;
  logic [31:0]             br_off;
  logic [4:0]              shamt;

  assign is_multi = MUL_DIV_EN &&
                    ((EXE_CMD == CMD_MUL) || (EXE_CMD == CMD_DIVU) || (EXE_CMD == CMD_REMU));

  // Divisor of zero makes div_ge always true: quotient all ones, remainder = dividend.
  assign div_shift = {acc_reg, a_reg[DATA_WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, b_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (is_multi) state_next = BUSY;
      BUSY:    if (count_reg == CNT_W'(DATA_WIDTH - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall      = ((state_reg == IDLE) && is_multi) || (state_reg == BUSY);
    ALU_result = (state_reg == DONE) ? engine_result : alu_result;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      cmd_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (is_multi) begin
            a_reg     <= Val1;
            b_reg     <= Val2;
            acc_reg   <= '0;
            cmd_reg   <= EXE_CMD;
            count_reg <= '0;
          end
        end
        BUSY: begin
          count_reg <= count_reg + CNT_W'(1);
          if (cmd_reg == CMD_MUL) begin
            if (a_reg[0]) acc_reg <= acc_reg + b_reg;
            a_reg <= a_reg >> 1;
            b_reg <= b_reg << 1;
          end else begin
            a_reg   <= {a_reg[DATA_WIDTH-2:0], div_ge};
            acc_reg <= div_ge ? (div_shift[DATA_WIDTH-1:0] - b_reg)
                              : div_shift[DATA_WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign engine_result = (cmd_reg == CMD_DIVU) ? a_reg : acc_reg;

  assign shamt = Val2[4:0];

  always_comb begin
    alu_result = '0;
    case (EXE_CMD)
      CMD_ADD: alu_result = Val1 + Val2;
      CMD_SUB: alu_result = Val1 - Val2;
      CMD_AND: alu_result = Val1 & Val2;
      CMD_OR:  alu_result = Val1 | Val2;
      CMD_NOR: alu_result = ~(Val1 | Val2);
      CMD_XOR: alu_result = Val1 ^ Val2;
      CMD_SLL: alu_result = Val1 << shamt;
      CMD_SRA: alu_result = $unsigned($signed(Val1) >>> shamt);
      CMD_SRL: alu_result = Val1 >> shamt;
      default: alu_result = '0;
    endcase
  end

  // Branch offset is treated as a signed word offset when operands are narrower than the PC.
  generate
    if (DATA_WIDTH >= 32) begin : g_off_wide
      assign br_off = Val2[31:0];
    end else begin : g_off_narrow
      assign br_off = {{(32 - DATA_WIDTH){Val2[DATA_WIDTH-1]}}, Val2};
    end
  endgenerate

  assign Br_addr  = PC_in + (br_off << 2);
  assign Br_taken = Br_taken_in;
  assign ST_value = Reg2;
  assign Dest_out = Dest;
  assign MEM_R_EN = MEM_R_EN_in & ~stall;
  assign MEM_W_EN = MEM_W_EN_in & ~stall;
  assign WB_EN    = WB_EN_in & ~stall;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: constant vector table, randomized ops against an
// arithmetic reference model, and hand sequences for the multi-cycle engine.
module tb_exe_stage;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   PC_in;
  logic [DW-1:0] Val1, Val2, Reg2;
  logic [4:0]    Dest;
  logic [3:0]    EXE_CMD;
  logic          Br_taken_in, MEM_R_EN_in, MEM_W_EN_in, WB_EN_in;
  logic [DW-1:0] ALU_result;
  logic [31:0]   Br_addr;
  logic          Br_taken;
  logic [DW-1:0] ST_value;
  logic [4:0]    Dest_out;
  logic          MEM_R_EN, MEM_W_EN, WB_EN, stall;

  int vectors = 0;
  int miscompares = 0;

  exe_stage #(.DATA_WIDTH(DW), .MUL_DIV_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .PC_in(PC_in), .Val1(Val1), .Val2(Val2), .Reg2(Reg2),
    .Dest(Dest), .EXE_CMD(EXE_CMD), .Br_taken_in(Br_taken_in),
    .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in), .WB_EN_in(WB_EN_in),
    .ALU_result(ALU_result), .Br_addr(Br_addr), .Br_taken(Br_taken),
    .ST_value(ST_value), .Dest_out(Dest_out), .MEM_R_EN(MEM_R_EN),
    .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[15];

  function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (c)
      4'd0:    return a + b;
      4'd2:    return a - b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return ~(a | b);
      4'd7:    return a ^ b;
      4'd8:    return a << b[4:0];
      4'd9:    return sa >>> b[4:0];
      4'd10:   return a >> b[4:0];
      4'd12:   return a * b;
      4'd13:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd14:   return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Counts stall cycles from the current point, then checks the presented result.
  task automatic measure(input string name, input logic [31:0] exp);
    int n;
    logic en_bad;
    n = 0;
    en_bad = 1'b0;
    while (stall && n < 200) begin
      if (WB_EN || MEM_R_EN || MEM_W_EN) en_bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_stall_cycles"}, n, DW + 1);
    chk({name, "_gated_en"}, {31'd0, en_bad}, 32'd0);
    chk({name, "_result"}, ALU_result, exp);
    chk({name, "_wb_en_done"}, {31'd0, WB_EN}, 32'd1);
    $display("multi %s: stall %0d cycles, result %h (expected %h)", name, n, ALU_result, exp);
  endtask

  task automatic run_multi(input string name, input logic [3:0] cmd, input logic [31:0] a,
                           input logic [31:0] b, input bit from_done, input bit flush);
    @(negedge clk);
    EXE_CMD = cmd; Val1 = a; Val2 = b;
    WB_EN_in = 1'b1; MEM_R_EN_in = 1'b1; MEM_W_EN_in = 1'b1;
    #1;
    if (from_done) begin
      chk({name, "_done_no_stall"}, {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
    end
    chk({name, "_stall_start"}, {31'd0, stall}, 32'd1);
    measure(name, model(cmd, a, b));
    if (flush) begin
      @(negedge clk);
      EXE_CMD = 4'b0011; MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    tbl[0]  = '{4'b0000, 32'd7,         32'hFFFF_FFFF, 32'd6};
    tbl[1]  = '{4'b0010, 32'd5,         32'd7,         32'hFFFF_FFFE};
    tbl[2]  = '{4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    tbl[3]  = '{4'b0101, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0};
    tbl[4]  = '{4'b0110, 32'd0,         32'd0,         32'hFFFF_FFFF};
    tbl[5]  = '{4'b0110, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000};
    tbl[6]  = '{4'b0111, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
    tbl[7]  = '{4'b1000, 32'd1,         32'd31,        32'h8000_0000};
    tbl[8]  = '{4'b1000, 32'd3,         32'h21,        32'd6};
    tbl[9]  = '{4'b1001, 32'h8000_0000, 32'd4,         32'hF800_0000};
    tbl[10] = '{4'b1010, 32'h8000_0000, 32'd4,         32'h0800_0000};
    tbl[11] = '{4'b0011, 32'd123,       32'd456,       32'd0};
    tbl[12] = '{4'b1111, 32'd123,       32'd456,       32'd0};
    tbl[13] = '{4'b0001, 32'd123,       32'd456,       32'd0};
    tbl[14] = '{4'b1011, 32'hFFFF_FFFF, 32'd1,         32'd0};

    rst = 1'b1;
    PC_in = 32'h100; Val1 = '0; Val2 = '0; Reg2 = '0; Dest = '0;
    EXE_CMD = 4'b0000; Br_taken_in = 1'b0;
    MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b0; WB_EN_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_result", ALU_result, 32'd0);
    EXE_CMD = 4'b1100;
    #1;
    chk("reset_mul_stall_comb", {31'd0, stall}, 32'd1);
    EXE_CMD = 4'b0000;
    @(negedge clk);
    rst = 1'b0;

    // Table of single-cycle ops
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      EXE_CMD = tbl[i].cmd; Val1 = tbl[i].a; Val2 = tbl[i].b; PC_in = 32'h100;
      WB_EN_in = 1'b1;
      #1;
      chk($sformatf("tbl%0d_result", i), ALU_result, tbl[i].exp);
      chk($sformatf("tbl%0d_stall", i), {31'd0, stall}, 32'd0);
      $display("table %0d: cmd %b a %h b %h -> %h", i, tbl[i].cmd, tbl[i].a, tbl[i].b, ALU_result);
      if (i == 0) begin
        chk("br_addr_neg", Br_addr, 32'h0000_00FC);
        chk("wb_en_single", {31'd0, WB_EN}, 32'd1);
      end
    end

    // Randomized single-cycle ops with pass-through fields
    for (int i = 0; i < 40; i++) begin
      logic [3:0] c;
      c = 4'($urandom_range(0, 15));
      if (c >= 4'd12 && c <= 4'd14) c = c ^ 4'b0100;
      @(negedge clk);
      EXE_CMD = c; Val1 = $urandom; Val2 = $urandom; PC_in = $urandom;
      Reg2 = $urandom; Dest = 5'($urandom);
      Br_taken_in = 1'($urandom); MEM_R_EN_in = 1'($urandom);
      MEM_W_EN_in = 1'($urandom); WB_EN_in = 1'($urandom);
      #1;
      chk("rnd_result", ALU_result, model(c, Val1, Val2));
      chk("rnd_br_addr", Br_addr, PC_in + (Val2 << 2));
      chk("rnd_st_value", ST_value, Reg2);
      chk("rnd_dest", {27'd0, Dest_out}, {27'd0, Dest});
      chk("rnd_ctrl", {28'd0, Br_taken, MEM_R_EN, MEM_W_EN, WB_EN},
          {28'd0, Br_taken_in, MEM_R_EN_in, MEM_W_EN_in, WB_EN_in});
      $display("random %0d: cmd %b a %h b %h -> %h", i, c, Val1, Val2, ALU_result);
    end

    // Multi-cycle corner cases
    run_multi("mul_1234x5678", 4'b1100, 32'd1234, 32'd5678, 1'b0, 1'b0);
    run_multi("mul_b2b_3x4",   4'b1100, 32'd3,    32'd4,    1'b1, 1'b1);
    run_multi("divu_100_7",    4'b1101, 32'd100,  32'd7,    1'b0, 1'b1);
    run_multi("remu_100_7",    4'b1110, 32'd100,  32'd7,    1'b0, 1'b1);
    run_multi("divu_5_0",      4'b1101, 32'd5,    32'd0,    1'b0, 1'b1);
    run_multi("remu_5_0",      4'b1110, 32'd5,    32'd0,    1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      logic [3:0] c;
      logic [31:0] b;
      c = 4'(12 + (i % 3));
      b = (i < 3) ? 32'($urandom) : 32'($urandom_range(1, 1000));
      run_multi($sformatf("rnd_multi%0d", i), c, $urandom, b, 1'b0, 1'b1);
    end

    // Reset while BUSY with count 10, MUL left on the inputs
    @(negedge clk);
    EXE_CMD = 4'b1100; Val1 = 32'd1234; Val2 = 32'd5678; WB_EN_in = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    chk("midop_busy_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midop_rst_stall", {31'd0, stall}, 32'd1);
    chk("midop_rst_wb_en", {31'd0, WB_EN}, 32'd0);
    #2;
    rst = 1'b0;
    measure("midop_restart", 32'd7006652);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
